// File: rtl/qs_fetch.sv
// Microcode fetch stage: PC register driving the ROM, one output register toward decode.
// Latency: the instruction at rom_ra appears on dec_* one cycle later; a redirect costs one bubble.
// Backpressure: dec_accept=0 with dec_vld=1 freezes the PC and the output register; a redirect always wins.
module qs_fetch #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    output logic [PC_W-1:0]   rom_ra,
    input  logic [INST_W-1:0] rom_rout,
    output logic              dec_vld,
    output logic [INST_W-1:0] dec_inst,
    output logic [PC_W-1:0]   dec_pc,
    input  logic              dec_accept,
    input  logic              xct_redirect,
    input  logic [PC_W-1:0]   xct_redirect_pc
);

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;
    typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

    state_t state_q, state_d;
    pc_t    pc_q, pc_d;
    pc_t    dpc_q, dpc_d;
    inst_t  inst_q, inst_d;
    pc_t    pc_seq, pc_next;
    logic   is_jmp, is_call, load;

    // Only unconditional J and CALL are resolved here; conditional J and RET are resolved by execute.
    assign is_jmp  = (rom_rout[15:12] == 4'b0001) && (rom_rout[9:8] == 2'b00);
    assign is_call = (rom_rout[15:11] == 5'b11000);
    assign pc_seq  = pc_q + pc_t'(1);
    assign pc_next = (is_jmp || is_call) ? pc_t'(rom_rout[7:0]) : pc_seq;
    assign load    = (state_q == IDLE) || dec_accept;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dpc_d   = dpc_q;
        inst_d  = inst_q;
        if (xct_redirect) begin
            state_d = IDLE;
            pc_d    = xct_redirect_pc;
        end else if (load) begin
            state_d = VALID;
            inst_d  = rom_rout;
            dpc_d   = pc_q;
            pc_d    = pc_next;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            dpc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dpc_q   <= dpc_d;
            inst_q  <= inst_d;
        end
    end

    assign rom_ra   = pc_q;
    assign dec_vld  = (state_q == VALID);
    assign dec_inst = inst_q;
    assign dec_pc   = dpc_q;

endmodule

// File: tb/tb_qs_fetch.sv
// Bench for qs_fetch: directed scenarios with literal expectations, then random accept/redirect
// traffic over a random ROM, all checked every cycle against a transaction-level model.
module tb_qs_fetch;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [7:0]  rom_ra;
    logic [15:0] rom_rout;
    logic        dec_vld;
    logic [15:0] dec_inst;
    logic [7:0]  dec_pc;
    logic        dec_accept;
    logic        xct_redirect;
    logic [7:0]  xct_redirect_pc;

    logic [15:0] rom [256];
    int n_tests = 0;
    int n_fail  = 0;

    // model state: fetch pointer and the instruction sitting in front of decode
    logic [7:0]  m_pc;
    logic        m_vld;
    logic [15:0] m_inst;
    logic [7:0]  m_dpc;

    always #5 clk = ~clk;

    assign rom_rout = rom[rom_ra];

    qs_fetch #(.PC_W(8), .INST_W(16)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .rom_ra         (rom_ra),
        .rom_rout       (rom_rout),
        .dec_vld        (dec_vld),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_accept     (dec_accept),
        .xct_redirect   (xct_redirect),
        .xct_redirect_pc(xct_redirect_pc)
    );

    function automatic logic [7:0] successor(input logic [15:0] i, input logic [7:0] pc);
        if (i[15:12] == 4'b0001 && i[9:8] == 2'b00) return i[7:0];
        if (i[15:11] == 5'b11000) return i[7:0];
        return pc + 8'd1;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_pc = 8'd0; m_vld = 1'b0; m_inst = 16'd0; m_dpc = 8'd0;
        end else if (xct_redirect) begin
            m_pc  = xct_redirect_pc;
            m_vld = 1'b0;
        end else if (!m_vld || dec_accept) begin
            m_inst = rom[m_pc];
            m_dpc  = m_pc;
            m_vld  = 1'b1;
            m_pc   = successor(m_inst, m_pc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("model_vld", 32'(dec_vld), 32'(m_vld));
        check("model_ra", 32'(rom_ra), 32'(m_pc));
        check("model_inst", 32'(dec_inst), 32'(m_inst));
        check("model_pc", 32'(dec_pc), 32'(m_dpc));
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic redirect_to(input logic [7:0] tgt);
        xct_redirect    = 1'b1;
        xct_redirect_pc = tgt;
        cyc();
        xct_redirect    = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        arst_n = 1'b0; dec_accept = 1'b0; xct_redirect = 1'b0; xct_redirect_pc = 8'd0;
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 5))
                0: w = {4'b0001, w[11:10], 2'b00, w[7:0]};
                1: w = {4'b0001, w[11:10], 2'b01, w[7:0]};
                2: w = {5'b11000, w[10:0]};
                default: ;
            endcase
            rom[a] = w;
        end
        rom[0]   = 16'h1020;  // J 32
        rom[35]  = 16'hC060;  // CALL 96
        rom[96]  = 16'h2000;
        rom[97]  = 16'h2001;
        rom[40]  = 16'h1120;  // conditional J, falls through
        rom[80]  = 16'h3000;
        rom[255] = 16'h4000;
        rom[128] = 16'h1080;  // self-loop J 128
        rom[70]  = 16'h2000;

        #1;
        check("rst_vld", 32'(dec_vld), 32'd0);
        check("rst_ra", 32'(rom_ra), 32'd0);
        check("rst_pc", 32'(dec_pc), 32'd0);
        repeat (2) cyc();
        arst_n = 1'b1; dec_accept = 1'b1;

        cyc();
        check("first_vld", 32'(dec_vld), 32'd1);
        check("first_inst", 32'(dec_inst), 32'h1020);
        check("first_pc", 32'(dec_pc), 32'd0);
        check("first_ra", 32'(rom_ra), 32'd32);

        redirect_to(8'd35);
        cyc();
        check("call_pc", 32'(dec_pc), 32'd35);
        check("call_ra", 32'(rom_ra), 32'd96);
        cyc();
        check("call_nobubble_vld", 32'(dec_vld), 32'd1);
        check("call_nobubble_pc", 32'(dec_pc), 32'd96);

        dec_accept = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("stall_pc", 32'(dec_pc), 32'd96);
            check("stall_inst", 32'(dec_inst), 32'h2000);
            check("stall_ra", 32'(rom_ra), 32'd97);
        end
        dec_accept = 1'b1;
        cyc();
        check("resume_pc", 32'(dec_pc), 32'd97);
        check("resume_ra", 32'(rom_ra), 32'd98);

        dec_accept = 1'b0;
        redirect_to(8'd80);
        check("redir_vld", 32'(dec_vld), 32'd0);
        check("redir_ra", 32'(rom_ra), 32'd80);
        cyc();
        check("redir_fetch_vld", 32'(dec_vld), 32'd1);
        check("redir_fetch_pc", 32'(dec_pc), 32'd80);

        dec_accept = 1'b1;
        xct_redirect = 1'b1; xct_redirect_pc = 8'd10;
        cyc();
        redirect_to(8'd40);
        cyc();
        check("b2b_pc", 32'(dec_pc), 32'd40);
        check("condj_ra", 32'(rom_ra), 32'd41);

        redirect_to(8'd255);
        cyc();
        check("wrap_pc", 32'(dec_pc), 32'd255);
        check("wrap_ra", 32'(rom_ra), 32'd0);

        redirect_to(8'd128);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("loop_pc", 32'(dec_pc), 32'd128);
            check("loop_ra", 32'(rom_ra), 32'd128);
        end

        redirect_to(8'd70);
        dec_accept = 1'b0;
        cyc();
        check("pre_rst_pc", 32'(dec_pc), 32'd70);
        #2 arst_n = 1'b0;
        #1;
        check("async_vld", 32'(dec_vld), 32'd0);
        check("async_ra", 32'(rom_ra), 32'd0);
        cyc();
        arst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            cyc();
            dec_accept      = ($urandom_range(0, 3) != 0);
            xct_redirect    = ($urandom_range(0, 9) == 0);
            xct_redirect_pc = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2 arst_n = 1'b0;
                #1 arst_n = 1'b1;
            end
        end
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qs_fetch.md
QS_FETCH -- requirements
Module: qs_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, microcode address width (pc_t).
REQ-002 SHALL have parameter INST_W, default 16, microcode instruction width (inst_t).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rom_ra  output  PC_W  current fetch PC, driven to the microcode ROM address.
REQ-006 SHALL have port rom_rout  input  INST_W  ROM instruction at rom_ra, combinational, same cycle.
REQ-007 SHALL have port dec_vld  output  1  decode-stage instruction valid.
REQ-008 SHALL have port dec_inst  output  INST_W  instruction presented to decode.
REQ-009 SHALL have port dec_pc  output  PC_W  address dec_inst was fetched from.
REQ-010 SHALL have port dec_accept  input  1  decode consumes dec_inst this cycle (valid only with dec_vld).
REQ-011 SHALL have port xct_redirect  input  1  execute resolved a taken conditional jump or RET.
REQ-012 SHALL have port xct_redirect_pc  input  PC_W  redirect target.

Function
REQ-013 SHALL hold an internal PC register; rom_ra SHALL equal the PC register.
REQ-014 SHALL hold one output register (dec_vld, dec_inst, dec_pc); "load" = output register empty or dec_accept=1.
REQ-015 On load without redirect, SHALL capture dec_inst<=rom_rout, dec_pc<=PC, dec_vld<=1, and update PC to next-PC.
REQ-016 Next-PC SHALL be rom_rout[7:0] when rom_rout[15:12]=0001 and rom_rout[9:8]=00 (unconditional J).
REQ-017 Next-PC SHALL be rom_rout[7:0] when rom_rout[15:11]=11000 (CALL); link PC is PC+1, computed by execute from dec_pc.
REQ-018 Next-PC SHALL otherwise be PC+1 modulo 2^PC_W (255 wraps to 0); conditional J, RET, WAIT and all others fall through.
REQ-019 Without load (dec_vld=1, dec_accept=0), PC and output register SHALL hold; dec_inst/dec_pc SHALL be stable while dec_vld=1.
REQ-020 xct_redirect=1 SHALL take priority over load: PC<=xct_redirect_pc, dec_vld<=0, and rom_rout that cycle discarded, whether or not dec_accept=1.
REQ-021 First valid instruction after redirect SHALL appear on dec_vld the cycle after the redirect edge (one bubble), with dec_pc=xct_redirect_pc.
REQ-022 Back-to-back redirects SHALL each overwrite PC; only the last target is fetched.
REQ-023 Throughput SHALL be one instruction per cycle with dec_accept held high and no redirect.
REQ-024 Self-loop J (target = own PC, e.g. error vector 128) SHALL refetch the same PC every accepted cycle indefinitely.
REQ-025 Fetch SHALL be state machine IDLE (dec_vld=0) / VALID (dec_vld=1): IDLE->VALID on fetch without redirect; VALID->IDLE on redirect; VALID->VALID on accept or stall.

Reset
REQ-026 While arst_n=0, PC SHALL be 0, dec_vld SHALL be 0, dec_inst and dec_pc SHALL be 0, asynchronously.
REQ-027 Assertion mid-operation SHALL drop dec_vld immediately, discarding any held instruction.
REQ-028 First fetch SHALL occur on the first rising clk edge after arst_n deasserts, from PC 0.

Verification
REQ-029 Reset release, ROM[0]=J 32, dec_accept=1 -> cycle 1 dec_vld=1, dec_inst=J 32, dec_pc=0; rom_ra=32.
REQ-030 PC=35 holding CALL 96, dec_accept=1 -> dec_pc=35 captured, rom_ra=96 next cycle, no bubble.
REQ-031 dec_vld=1, dec_accept=0 for 5 cycles -> dec_inst, dec_pc, rom_ra unchanged throughout; accept resumes at PC+1.
REQ-032 xct_redirect=1, xct_redirect_pc=80, dec_accept=0 -> next cycle dec_vld=0, rom_ra=80; following cycle dec_pc=80.
REQ-033 PC=255 with non-jump instruction, accepted -> rom_ra=0 next cycle.
REQ-034 arst_n pulsed low while dec_vld=1 at PC=70 -> dec_vld=0 and rom_ra=0 without waiting for clk.
